// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one external ALU between two requesters. Port 0 is typically the EX
// stage and port 1 the branch/address unit. Requests are arbitrated
// round-robin. The winning operands are registered into a single issue stage
// that drives the ALU. The ALU outputs are captured one cycle later into a
// per-port response register, which holds until that port acknowledges it.
// Each port has at most one transaction in flight. Accept-to-response latency
// is always two cycles.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   req_valid / req_ready     per-port request handshake (bit i = port i)
//   req_a0/b0/op0             port 0 operands and operation code
//   req_a1/b1/op1             port 1 operands and operation code
//   alu_a / alu_b / alu_op    drive the ALU Adat / Bdat / ALUoper
//                             (forced to 0 when the issue stage is idle)
//   alu_result, alu_zero,
//   alu_cout, alu_ovf         ALU Result / zero / carryout / overflow
//   rsp_valid / rsp_ready     per-port response handshake
//   rsp_result0/1             captured Result per port
//   rsp_flags0/1              captured {overflow, carryout, zero} per port
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int DW  = 32,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [DW-1:0]  req_a0,
    input  logic [DW-1:0]  req_b0,
    input  logic [OPW-1:0] req_op0,
    input  logic [DW-1:0]  req_a1,
    input  logic [DW-1:0]  req_b1,
    input  logic [OPW-1:0] req_op1,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_result,
    input  logic           alu_zero,
    input  logic           alu_cout,
    input  logic           alu_ovf,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [DW-1:0]  rsp_result0,
    output logic [DW-1:0]  rsp_result1,
    output logic [2:0]     rsp_flags0,
    output logic [2:0]     rsp_flags1
);

    // Outstanding-transaction tracking and round-robin pointer
    logic [1:0]            busy_q, busy_d;
    logic                  last_grant_q;

    // Issue stage feeding the ALU
    logic                  issue_valid_q;
    logic                  issue_id_q;
    logic [DW-1:0]         issue_a_q, issue_b_q;
    logic [OPW-1:0]        issue_op_q;

    // Per-port response registers
    logic [1:0]            rsp_valid_q;
    logic [1:0][DW-1:0]    rsp_result_q;
    logic [1:0][2:0]       rsp_flags_q;

    logic [1:0]            elig, grant, accept, rsp_hs;

    // NOTE: every signal written in always_comb gets a default before any
    // conditional assignment, so no path can leave it unassigned (no latch).
    always_comb begin
        elig  = req_valid & ~busy_q;
        grant = 2'b00;
        // Grants are suppressed during reset so req_ready reads 0 while rst is high.
        if (!rst) begin
            if (elig == 2'b11) begin
                // Tie: the port that did not win last time goes next.
                grant = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                grant = elig;
            end
        end
    end

    assign req_ready = grant;
    assign accept    = req_valid & grant;
    assign rsp_hs    = rsp_valid_q & rsp_ready;

    // An accept needs busy=0 and a handshake needs rsp_valid=1 (which implies
    // busy=1). So both cannot hit the same port in one cycle.
    assign busy_d = (busy_q | accept) & ~rsp_hs;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= 2'b00;
            last_grant_q  <= 1'b1;
            issue_valid_q <= 1'b0;
            issue_id_q    <= 1'b0;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_op_q    <= '0;
            rsp_valid_q   <= 2'b00;
            // NOTE: the response data registers are reset too. They are
            // visible outputs that must read 0 after reset, not just
            // don't-care storage.
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
        end else begin
            busy_q        <= busy_d;
            issue_valid_q <= |accept;
            if (|accept) begin
                last_grant_q <= accept[1];
                issue_id_q   <= accept[1];
                issue_a_q    <= accept[1] ? req_a1  : req_a0;
                issue_b_q    <= accept[1] ? req_b1  : req_b0;
                issue_op_q   <= accept[1] ? req_op1 : req_op0;
            end

            // A held response drops the cycle after its handshake.
            rsp_valid_q <= rsp_valid_q & ~rsp_hs;

            // The ALU is combinational on the issue registers: capture at the
            // end of the issue cycle. The target port is busy, so its
            // response slot is guaranteed free.
            if (issue_valid_q) begin
                rsp_valid_q[issue_id_q]  <= 1'b1;
                rsp_result_q[issue_id_q] <= alu_result;
                rsp_flags_q[issue_id_q]  <= {alu_ovf, alu_cout, alu_zero};
            end
        end
    end

    // Stale issue operands must not reach the ALU when the stage is idle.
    assign alu_a  = issue_valid_q ? issue_a_q  : '0;
    assign alu_b  = issue_valid_q ? issue_b_q  : '0;
    assign alu_op = issue_valid_q ? issue_op_q : '0;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_result0 = rsp_result_q[0];
    assign rsp_result1 = rsp_result_q[1];
    assign rsp_flags0  = rsp_flags_q[0];
    assign rsp_flags1  = rsp_flags_q[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Scoreboard bench for alu_share_arbiter.
//
// A behavioural ALU (ADD for op 0) answers the DUT's ALU interface. A
// reference process applies the arbitration rules each cycle: eligibility,
// round-robin tie break, one outstanding transaction per port. On every
// accept it pushes the expected response (value, flags, due cycle) into a
// per-port queue. A separate monitor pops and compares whenever a response
// appears. It also checks that responses hold while unacknowledged and
// drop after the handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_share_arbiter;

    localparam int DW  = 32;
    localparam int OPW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [DW-1:0]  req_a0, req_b0, req_a1, req_b1;
    logic [OPW-1:0] req_op0, req_op1, alu_op;
    logic [DW-1:0]  alu_a, alu_b, alu_result, rsp_result0, rsp_result1;
    logic           alu_zero, alu_cout, alu_ovf;
    logic [2:0]     rsp_flags0, rsp_flags1;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DW(DW), .OPW(OPW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_op0    (req_op0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .req_op1    (req_op1),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_cout   (alu_cout),
        .alu_ovf    (alu_ovf),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result0(rsp_result0),
        .rsp_result1(rsp_result1),
        .rsp_flags0 (rsp_flags0),
        .rsp_flags1 (rsp_flags1)
    );

    // ---------------- counters and check ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- ALU behaviour: {ovf, cout, zero, result} ----------------
    function automatic logic [DW+2:0] add_ref(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0]   s;
        logic [DW-1:0] r;
        s = {1'b0, a} + {1'b0, b};
        r = s[DW-1:0];
        return {(a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]), s[DW], r == '0, r};
    endfunction

    logic [DW+2:0] alu_model;
    assign alu_model  = (alu_op == 3'd0) ? add_ref(alu_a, alu_b) : '0;
    assign alu_result = alu_model[DW-1:0];
    assign alu_zero   = alu_model[DW];
    assign alu_cout   = alu_model[DW+1];
    assign alu_ovf    = alu_model[DW+2];

    // ---------------- scoreboard queues ----------------
    typedef struct {
        logic [DW-1:0] result;
        logic [2:0]    flags;
        int            due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // ---------------- reference model (arbitration + expected responses) ----------------
    logic [1:0]     m_busy   = 2'b00;
    logic           m_last   = 1'b1;
    logic [1:0]     acc_flag = 2'b00;
    logic           exp_iv   = 1'b0;
    logic [DW-1:0]  exp_ia   = '0, exp_ib = '0;
    logic [OPW-1:0] exp_iop  = '0;
    int             acc_cnt [2] = '{0, 0};
    logic [1:0]     m_elig, m_gr;
    logic [DW-1:0]  m_a, m_b;
    logic [OPW-1:0] m_op;
    logic [DW+2:0]  m_r;
    exp_t           m_e;

    always @(negedge clk) begin
        if (rst) begin
            check("ready_in_reset", req_ready, 2'b00);
            m_busy   = 2'b00;
            m_last   = 1'b1;
            acc_flag = 2'b00;
            exp_iv   = 1'b0;
            q0.delete();
            q1.delete();
        end else begin
            // Issue stage loaded by last cycle's accept (or idle -> zeros)
            check("alu_a",  alu_a,  exp_iv ? exp_ia  : '0);
            check("alu_b",  alu_b,  exp_iv ? exp_ib  : '0);
            check("alu_op", alu_op, exp_iv ? exp_iop : '0);

            m_elig = req_valid & ~m_busy;
            m_gr   = 2'b00;
            if (m_elig == 2'b11) m_gr[m_last ? 0 : 1] = 1'b1;
            else                 m_gr = m_elig;
            check("req_ready", req_ready, m_gr);

            acc_flag = req_valid & m_gr;
            exp_iv   = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (acc_flag[i]) begin
                    m_a  = (i == 1) ? req_a1  : req_a0;
                    m_b  = (i == 1) ? req_b1  : req_b0;
                    m_op = (i == 1) ? req_op1 : req_op0;
                    m_r  = add_ref(m_a, m_b);
                    m_e.result = m_r[DW-1:0];
                    m_e.flags  = m_r[DW+2:DW];
                    m_e.due    = cyc + 2;
                    if (i == 0) q0.push_back(m_e);
                    else        q1.push_back(m_e);
                    m_busy[i] = 1'b1;
                    m_last    = i[0];
                    acc_cnt[i]++;
                    exp_iv  = 1'b1;
                    exp_ia  = m_a;
                    exp_ib  = m_b;
                    exp_iop = m_op;
                end
            end
            // A response handshake frees the port from the next cycle on
            for (int i = 0; i < 2; i++)
                if (rsp_valid[i] && rsp_ready[i]) m_busy[i] = 1'b0;
        end
    end

    // ---------------- response monitor ----------------
    logic [1:0]    mon_prev = 2'b00, mon_ack = 2'b00;
    logic          mon_post = 1'b0;
    logic [DW-1:0] held_r [2];
    logic [2:0]    held_f [2];
    exp_t          n_e;
    logic          n_v;
    logic [DW-1:0] n_r;
    logic [2:0]    n_f;
    int            n_sz;

    always @(negedge clk) begin
        if (rst) begin
            mon_prev = 2'b00;
            mon_ack  = 2'b00;
            mon_post = 1'b1;
        end else begin
            if (mon_post) begin
                check("post_reset_rsp_valid", rsp_valid, 2'b00);
                check("post_reset_result0", rsp_result0, '0);
                check("post_reset_result1", rsp_result1, '0);
                check("post_reset_flags0", rsp_flags0, 3'b000);
                check("post_reset_flags1", rsp_flags1, 3'b000);
                mon_post = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                n_v  = rsp_valid[i];
                n_r  = (i == 1) ? rsp_result1 : rsp_result0;
                n_f  = (i == 1) ? rsp_flags1  : rsp_flags0;
                n_sz = (i == 1) ? q1.size() : q0.size();

                // Overdue expectation: the response never showed up in time
                if (n_sz > 0) begin
                    n_e = (i == 1) ? q1[0] : q0[0];
                    if (n_e.due < cyc) begin
                        check($sformatf("rsp%0d_missing_cycle", i), cyc, n_e.due);
                        if (i == 1) void'(q1.pop_front());
                        else        void'(q0.pop_front());
                        n_sz--;
                    end
                end

                if (mon_ack[i]) check($sformatf("rsp%0d_drop_after_ack", i), n_v, 1'b0);

                if (n_v && !mon_prev[i]) begin
                    if (n_sz == 0) begin
                        check($sformatf("rsp%0d_unexpected", i), n_v, 1'b0);
                    end else begin
                        if (i == 1) n_e = q1.pop_front();
                        else        n_e = q0.pop_front();
                        check($sformatf("rsp%0d_result", i), n_r, n_e.result);
                        check($sformatf("rsp%0d_flags", i), n_f, n_e.flags);
                        check($sformatf("rsp%0d_latency_cycle", i), cyc, n_e.due);
                    end
                    held_r[i] = n_r;
                    held_f[i] = n_f;
                end else if (n_v) begin
                    check($sformatf("rsp%0d_hold_result", i), n_r, held_r[i]);
                    check($sformatf("rsp%0d_hold_flags", i), n_f, held_f[i]);
                end

                mon_ack[i]  = n_v & rsp_ready[i];
                mon_prev[i] = n_v;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [DW-1:0] rand_opnd();
        case ($urandom_range(5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic new_req(input int p, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (p == 0) begin
            req_a0 = a; req_b0 = b; req_op0 = 3'd0;
        end else begin
            req_a1 = a; req_b1 = b; req_op1 = 3'd0;
        end
        req_valid[p] = 1'b1;
    endtask

    // Runs n cycles. A request is dropped once accepted; an idle enabled port
    // issues a new one with probability issue_pct. rsp_ready is redrawn each
    // cycle with probability rdy_pct.
    task automatic cycles(input int n, input logic [1:0] en, input int issue_pct, input int rdy_pct);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && acc_flag[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && en[i] && (int'($urandom_range(99)) < issue_pct))
                    new_req(i, rand_opnd(), rand_opnd());
                rsp_ready[i] = (int'($urandom_range(99)) < rdy_pct);
            end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    int b0, b1, d0, d1;

    initial begin
        rst = 1'b1;
        req_valid = 2'b00; rsp_ready = 2'b00;
        req_a0 = '0; req_b0 = '0; req_op0 = '0;
        req_a1 = '0; req_b1 = '0; req_op1 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single request 5+7 on port 0, response held without ack
        new_req(0, 32'd5, 32'd7);
        cycles(5, 2'b00, 0, 0);
        check("single_rsp_valid0", rsp_valid[0], 1'b1);
        check("single_result0", rsp_result0, 32'd12);
        check("single_flags0", rsp_flags0, 3'b000);
        cycles(2, 2'b00, 0, 100);
        cycles(2, 2'b00, 0, 0);

        // Tie: port 0 wins first (last_grant=1 after reset), port 1 follows
        new_req(0, 32'd1, 32'd1);
        new_req(1, 32'hFFFF_FFFF, 32'd1);
        cycles(8, 2'b00, 0, 100);

        // Overflow on port 1, with a second request held while busy
        new_req(1, 32'h7FFF_FFFF, 32'd1);
        cycles(6, 2'b10, 100, 0);
        cycles(6, 2'b10, 100, 100);
        cycles(6, 2'b00, 0, 100);

        // Round-robin: both ports always requesting, responses acked at once
        b0 = acc_cnt[0];
        b1 = acc_cnt[1];
        cycles(40, 2'b11, 100, 100);
        d0 = acc_cnt[0] - b0;
        d1 = acc_cnt[1] - b1;
        check("rr_balance", ((d0 > d1) ? d0 - d1 : d1 - d0) <= 1, 1'b1);
        check("rr_progress", d0 + d1 >= 20, 1'b1);
        cycles(6, 2'b00, 0, 100);

        // Randomised traffic
        cycles(1500, 2'b11, 50, 60);
        cycles(10, 2'b00, 0, 100);

        // Reset in the cycle after a port 0 accept: the response is discarded
        new_req(0, rand_opnd(), rand_opnd());
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        cycles(6, 2'b00, 0, 100);

        // Tie after reset again goes to port 0
        new_req(0, rand_opnd(), rand_opnd());
        new_req(1, rand_opnd(), rand_opnd());
        #1;
        check("tie_after_reset_ready", req_ready, 2'b01);
        cycles(8, 2'b00, 0, 100);

        // Drain and make sure nothing expected is left outstanding
        cycles(20, 2'b00, 0, 100);
        check("drain_q0_empty", q0.size(), 0);
        check("drain_q1_empty", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 32-bit ALU between two requesters, e.g. the EX stage (port 0) and the branch/address unit (port 1).
- Arbitrates requests round-robin and registers the selected operands into an issue stage that drives the ALU.
- Captures ALU Result and flags into a per-port response register, which holds until that port acknowledges.
- The ALU itself is instantiated outside this block; the arbiter connects only to its Adat/Bdat/ALUoper inputs and Result/zero/carryout/overflow outputs.

Parameters:
- DW, 32, operand/result width; must match the ALU.
- OPW, 3, ALU operation code width; the arbiter passes the code through without decoding it.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  2  per-port request valid; bit i belongs to port i.
- req_ready  out  2  per-port request accept.
- req_a0, req_b0  in  DW each  port 0 operands.
- req_op0  in  OPW  port 0 ALU operation code.
- req_a1, req_b1  in  DW each  port 1 operands.
- req_op1  in  OPW  port 1 ALU operation code.
- alu_a  out  DW  drives ALU Adat.
- alu_b  out  DW  drives ALU Bdat.
- alu_op  out  OPW  drives ALU ALUoper.
- alu_result  in  DW  from ALU Result.
- alu_zero, alu_cout, alu_ovf  in  1 each  from ALU zero, carryout, overflow.
- rsp_valid  out  2  per-port response valid.
- rsp_ready  in  2  per-port response accept.
- rsp_result0, rsp_result1  out  DW each  captured Result per port.
- rsp_flags0, rsp_flags1  out  3 each  captured {overflow, carryout, zero} per port.

Behaviour:
- Reset: synchronous, active-high on rst; the interface is one clock (clk).
  - All outputs 0: req_ready, rsp_valid, rsp_result*, rsp_flags*, alu_a, alu_b, alu_op.
  - issue_valid=0, busy[1:0]=0, last_grant=1, so port 0 wins the first tie.
- Eligibility:
  - elig_i = req_valid[i] & ~busy[i].
  - busy[i] is set on accept and cleared the cycle after the rsp_valid[i] & rsp_ready[i] handshake.
  - Each port has at most one transaction outstanding.
- Arbitration: combinational, at most one grant per cycle.
  - Only one port eligible: grant it.
  - Both eligible: grant the port != last_grant.
  - req_ready[i] = grant[i]; it may depend on req_valid.
  - Accept = req_valid[i] & req_ready[i]; last_grant <= i on accept.
- Pipeline, for an accept in cycle N:
  - N: requester's a/b/op and id latched into issue registers; issue_valid <= 1.
  - N+1: alu_a/alu_b/alu_op driven from the issue registers; ALU outputs are combinational; the response register of port id captures alu_result and the flags at the end of N+1.
  - N+2: rsp_valid[id]=1.
  - Accept-to-response latency is exactly 2 cycles, independent of the other port.
- Back-to-back operation:
  - A new accept from the other port in N+1 reloads the issue registers.
  - Issue throughput is one operation per cycle across both ports.
- Idle issue stage (issue_valid=0): alu_a, alu_b and alu_op are forced to 0.
- Response hold:
  - rsp_valid[i], rsp_result and rsp_flags stay stable until rsp_ready[i] is sampled high.
  - rsp_valid[i] drops the following cycle.
  - rsp_ready while rsp_valid=0 is ignored.
- Re-request timing:
  - busy[i] clears one cycle after the response handshake.
  - The earliest re-accept is the cycle after that handshake; there is no same-cycle bypass.
- Simultaneous events: a response handshake on one port and an accept on the other port in the same cycle are independent and both take effect.
- Reset mid-operation: an in-flight issue and any pending responses are discarded with no response; the state returns to the reset values above.
- Width rules: results and flags are captured exactly as the ALU produces them; the arbiter performs no arithmetic.

Test Plan:
- Bench ALU model: op 3'd0 = ADD, used in all scenarios.
- Single request: port 0 sends a=5, b=7, op=0 at cycle N -> alu_a=5, alu_b=7 in N+1; rsp_valid[0]=1, rsp_result0=12, flags=3'b000 at N+2; outputs held while rsp_ready[0]=0.
- Tie after reset: both ports valid in the same cycle (port 0: 1+1; port 1: 0xFFFFFFFF+1) -> port 0 granted first, port 1 the next cycle; rsp_result1=0 with flags zero=1, carry=1 (3'b011), one cycle after port 0's response.
- Round-robin: both ports held valid, responses acked immediately -> grants alternate 0,1,0,1 with no port accepted twice in a row.
- Overflow path: port 1 sends 0x7FFFFFFF+1 -> rsp_result1=0x80000000, flags=3'b100; port 1 req_ready stays 0 until the cycle after its rsp handshake.
- Reset: rst=1 in the N+1 cycle after a port 0 accept -> no rsp_valid ever appears for that request; all outputs 0; the next tie after reset grants port 0.
